// File: rtl/perceptron_pkg.sv
// Shared widths, opcodes and state encodings for the UART-attached perceptron.
package perceptron_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned SUM_W  = 18;

   localparam logic [DATA_W-1:0] OPC_LOAD_W = 8'h00;
   localparam logic [DATA_W-1:0] OPC_LOAD_X = 8'h01;

   typedef enum logic [2:0] {
      IDLE,
      OPC,
      DATA,
      SKIP,
      CALC,
      SEND
   } state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_BITS,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/perceptron_uart.sv
// 8N1 UART: synchronised receiver with centre sampling and a byte strobe,
// plus a transmitter that can chain bytes with no idle gap.
module perceptron_uart
   import perceptron_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 430
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              tx_start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready_c,
   output logic              tx
);

   localparam int unsigned      CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

   logic [2:0]        sync;
   logic              rx_line;
   logic              rx_fall;
   rx_state_t         rx_state;
   rx_state_t         rx_state_next;
   logic [CNT_W-1:0]  rx_cnt;
   logic [2:0]        rx_bit;
   logic [DATA_W-1:0] rx_shift;

   logic [DATA_W:0]   tx_shift;
   logic [3:0]        tx_bit;
   logic [CNT_W-1:0]  tx_cnt;
   logic              tx_busy;

   // sync[1] is the synchronised line, sync[2] its previous value for edge detect
   always_ff @(posedge clk) begin
      if (rst) sync <= '1;
      else     sync <= {sync[1:0], rx};
   end

   assign rx_line = sync[1];
   assign rx_fall = sync[2] & ~sync[1];

   always_comb begin
      rx_state_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (rx_fall) rx_state_next = RX_START;
         RX_START: if (rx_cnt == CNT_HALF) rx_state_next = rx_line ? RX_IDLE : RX_BITS;
         RX_BITS:  if (rx_cnt == CNT_LAST && rx_bit == 3'd7) rx_state_next = RX_STOP;
         RX_STOP:  if (rx_cnt == CNT_LAST) rx_state_next = RX_IDLE;
         default:  rx_state_next = RX_IDLE;
      endcase
   end

   // Counter restarts on every state change so each phase is timed from its own start
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_state <= rx_state_next;
         rx_valid <= 1'b0;
         if (rx_state == RX_IDLE || rx_state != rx_state_next || rx_cnt == CNT_LAST)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 1'b1;
         if (rx_state == RX_START) rx_bit <= '0;
         if (rx_state == RX_BITS && rx_cnt == CNT_LAST) begin
            rx_shift <= {rx_line, rx_shift[DATA_W-1:1]};
            rx_bit   <= rx_bit + 1'b1;
         end
         if (rx_state == RX_STOP && rx_cnt == CNT_LAST && rx_line) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
         end
      end
   end

   // Ready also at the last cycle of a stop bit so replies chain back-to-back
   assign tx_ready_c = !tx_busy || (tx_bit == 4'd9 && tx_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         tx_shift <= '1;
         tx_bit   <= '0;
         tx_cnt   <= '0;
      end else if (tx_start && tx_ready_c) begin
         tx       <= 1'b0;
         tx_busy  <= 1'b1;
         tx_shift <= {1'b1, tx_data};
         tx_bit   <= '0;
         tx_cnt   <= '0;
      end else if (tx_busy) begin
         if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx       <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[DATA_W:1]};
            if (tx_bit == 4'd9) tx_busy <= 1'b0;
            else                tx_bit  <= tx_bit + 1'b1;
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/perceptron_core.sv
// Single-neuron perceptron: parses addressed UART frames into weights/inputs,
// runs a 4-cycle MAC and returns the sum and threshold decision.
module perceptron_core
   import perceptron_pkg::*;
#(
   parameter int unsigned BAUD_DIV  = 430,
   parameter int unsigned NODE_ADDR = 100,
   parameter int unsigned N_IN      = 4,
   parameter int unsigned THRESHOLD = 255
) (
   input  logic clk,
   input  logic nRst,
   input  logic host_tx,
   output logic uart_tx
);

   localparam int unsigned       IDX_W       = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(N_IN - 1);
   localparam int unsigned       SKIP_W      = $clog2(N_IN + 2);
   localparam logic [SKIP_W-1:0] SKIP_BYTES  = SKIP_W'(N_IN + 1);
   localparam logic [2:0]        REPLY_BYTES = 3'd4;
   localparam logic [DATA_W-1:0] ADDR_BYTE   = DATA_W'(NODE_ADDR);

   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              tx_start_c;
   logic [DATA_W-1:0] tx_byte_c;
   logic              tx_ready_c;

   state_t            parse_state;
   state_t            parse_next;
   logic [DATA_W-1:0] opcode;
   logic [IDX_W-1:0]  idx;
   logic [SKIP_W-1:0] skip_cnt;
   logic [DATA_W-1:0] w [N_IN];
   logic [DATA_W-1:0] x [N_IN];
   logic              calc_req_c;

   state_t            eng_state;
   state_t            eng_next;
   logic [IDX_W-1:0]  mac_idx;
   logic [SUM_W-1:0]  acc;
   logic [2:0]        send_idx;
   logic              pending;
   logic              act_c;

   perceptron_uart #(
      .BAUD_DIV (BAUD_DIV)
   ) u_uart (
      .clk        (clk),
      .rst        (nRst),
      .rx         (host_tx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_start   (tx_start_c),
      .tx_data    (tx_byte_c),
      .tx_ready_c (tx_ready_c),
      .tx         (uart_tx)
   );

   // Frame parser: ADDR, OPCODE, then N_IN data bytes
   always_comb begin
      parse_next = parse_state;
      calc_req_c = 1'b0;
      if (rx_valid) begin
         case (parse_state)
            IDLE: parse_next = (rx_data == ADDR_BYTE) ? OPC : SKIP;
            OPC:  parse_next = DATA;
            DATA: if (idx == IDX_LAST) begin
                     parse_next = IDLE;
                     calc_req_c = (opcode == OPC_LOAD_X);
                  end
            SKIP: if (skip_cnt == SKIP_W'(1)) parse_next = IDLE;
            default: parse_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (nRst) begin
         parse_state <= IDLE;
         opcode      <= '0;
         idx         <= '0;
         skip_cnt    <= '0;
         w           <= '{default: '0};
         x           <= '{default: '0};
      end else begin
         parse_state <= parse_next;
         if (rx_valid) begin
            case (parse_state)
               IDLE: skip_cnt <= SKIP_BYTES;
               OPC: begin
                  opcode <= rx_data;
                  idx    <= '0;
               end
               DATA: begin
                  if (opcode == OPC_LOAD_W)      w[idx] <= rx_data;
                  else if (opcode == OPC_LOAD_X) x[idx] <= rx_data;
                  idx <= idx + 1'b1;
               end
               SKIP: skip_cnt <= skip_cnt - 1'b1;
               default: ;
            endcase
         end
      end
   end

   assign act_c = (acc > SUM_W'(THRESHOLD));

   // Compute/reply engine; a request that lands while busy is held in pending
   always_comb begin
      eng_next   = eng_state;
      tx_start_c = 1'b0;
      case (eng_state)
         IDLE: if (calc_req_c || pending) eng_next = CALC;
         CALC: if (mac_idx == IDX_LAST) eng_next = SEND;
         SEND: if (tx_ready_c) begin
                  if (send_idx == REPLY_BYTES) eng_next = IDLE;
                  else                         tx_start_c = 1'b1;
               end
         default: eng_next = IDLE;
      endcase
   end

   always_comb begin
      tx_byte_c = '0;
      case (send_idx)
         3'd0:    tx_byte_c = acc[7:0];
         3'd1:    tx_byte_c = acc[15:8];
         3'd2:    tx_byte_c = DATA_W'(acc[SUM_W-1:16]);
         3'd3:    tx_byte_c = DATA_W'(act_c);
         default: tx_byte_c = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (nRst) begin
         eng_state <= IDLE;
         mac_idx   <= '0;
         acc       <= '0;
         send_idx  <= '0;
         pending   <= 1'b0;
      end else begin
         eng_state <= eng_next;
         case (eng_state)
            IDLE: begin
               acc      <= '0;
               mac_idx  <= '0;
               send_idx <= '0;
            end
            CALC: begin
               acc     <= acc + (SUM_W'(w[mac_idx]) * SUM_W'(x[mac_idx]));
               mac_idx <= mac_idx + 1'b1;
            end
            SEND: if (tx_start_c) send_idx <= send_idx + 1'b1;
            default: ;
         endcase
         if (eng_state == IDLE && eng_next == CALC) pending <= 1'b0;
         else if (calc_req_c)                       pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_perceptron_core.sv
// Bench for perceptron_core: drives UART frames, decodes replies and compares
// them with a frame-level arithmetic model of the neuron.
`timescale 1ns/1ps
module tb_perceptron_core;

   localparam int unsigned BAUD = 16;
   localparam int unsigned NODE = 100;
   localparam int unsigned THR  = 255;

   logic clk = 1'b0;
   logic nRst;
   logic host_tx;
   logic uart_tx;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int last_stop = 0;

   logic [7:0]  got_q[$];
   int          st_q[$];
   logic [7:0]  exp_q[$];
   int unsigned w_m[4];
   int unsigned x_m[4];

   perceptron_core #(
      .BAUD_DIV  (BAUD),
      .NODE_ADDR (NODE),
      .N_IN      (4),
      .THRESHOLD (THR)
   ) dut (
      .clk     (clk),
      .nRst    (nRst),
      .host_tx (host_tx),
      .uart_tx (uart_tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Reply decoder: records each byte and the cycle its start bit was seen
   initial begin : monitor
      logic [7:0] b;
      int st;
      b = '0;
      forever begin
         @(negedge clk);
         if (uart_tx === 1'b0) begin
            st = cyc;
            repeat (BAUD / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BAUD) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (BAUD) @(negedge clk);
            got_q.push_back(b);
            st_q.push_back(st);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      @(negedge clk);
      host_tx = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         host_tx = b[i];
         repeat (BAUD) @(negedge clk);
      end
      last_stop = cyc;
      host_tx = !bad_stop;
      repeat (BAUD) @(negedge clk);
      host_tx = 1'b1;
      if (bad_stop) repeat (BAUD) @(negedge clk);
   endtask

   function automatic void model_frame(input int unsigned addr, input int unsigned opc,
                                       input int unsigned d[4]);
      int unsigned sum;
      if (addr != NODE) return;
      if (opc == 0) begin
         w_m = d;
      end else if (opc == 1) begin
         x_m = d;
         sum = 0;
         for (int i = 0; i < 4; i++) sum += w_m[i] * x_m[i];
         exp_q.push_back(8'(sum));
         exp_q.push_back(8'(sum >> 8));
         exp_q.push_back(8'(sum >> 16));
         exp_q.push_back((sum > THR) ? 8'h01 : 8'h00);
      end
   endfunction

   task automatic send_frame(input int unsigned addr, input int unsigned opc,
                             input int unsigned d[4]);
      send_byte(8'(addr), 1'b0);
      send_byte(8'(opc), 1'b0);
      for (int i = 0; i < 4; i++) send_byte(8'(d[i]), 1'b0);
      model_frame(addr, opc, d);
   endtask

   task automatic check_reply(input string tag);
      int n;
      int lat;
      repeat (46 * BAUD) @(negedge clk);
      n = exp_q.size();
      chk({tag, ".count"}, got_q.size(), n);
      if (got_q.size() > 0) begin
         lat = st_q[0] - last_stop;
         chk({tag, ".latency_ok"}, (lat >= 1 && lat <= int'(BAUD / 2 + 12)), 1);
      end
      for (int k = 0; k < n && k < got_q.size(); k++) begin
         chk($sformatf("%s.byte%0d", tag, k), got_q[k], exp_q[k]);
         if (k > 0) chk($sformatf("%s.gap%0d", tag, k), st_q[k] - st_q[k-1], 10 * BAUD);
      end
      got_q.delete();
      st_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      nRst = 1'b1;
      @(negedge clk);
      nRst = 1'b0;
      w_m = '{default: 0};
      x_m = '{default: 0};
   endtask

   initial begin
      int unsigned d[4];
      int lows;
      bit found;
      int unsigned a;
      int unsigned o;

      nRst    = 1'b1;
      host_tx = 1'b1;
      w_m = '{default: 0};
      x_m = '{default: 0};
      repeat (3) @(negedge clk);
      nRst = 1'b0;
      chk("reset_tx_high", uart_tx, 1);

      lows = 0;
      repeat (2000) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      chk("idle_tx_low_cycles", lows, 0);
      chk("idle_bytes", got_q.size(), 0);

      d = '{1, 2, 3, 4};     send_frame(NODE, 0, d); check_reply("load_w");
      d = '{10, 20, 30, 40}; send_frame(NODE, 1, d); check_reply("sum300");
      d = '{1, 1, 1, 1};     send_frame(NODE, 1, d); check_reply("sum10");

      d = '{10, 20, 30, 40}; send_frame(99, 1, d);
      d = '{5, 6, 7, 8};     send_frame(NODE, 1, d); check_reply("wrong_addr");

      d = '{255, 255, 255, 255};
      send_frame(NODE, 0, d); check_reply("w_max");
      send_frame(NODE, 1, d); check_reply("sum_max");

      // byte with a low stop bit is dropped; the four good bytes complete the frame
      send_byte(8'(NODE), 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h55, 1'b1);
      d = '{1, 2, 3, 4};
      for (int i = 0; i < 4; i++) send_byte(8'(d[i]), 1'b0);
      model_frame(NODE, 1, d);
      check_reply("framing_err");

      // partial frame, then reset: parser must restart at ADDR
      send_byte(8'(NODE), 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h07, 1'b0);
      send_byte(8'h07, 1'b0);
      do_reset();
      repeat (4 * BAUD) @(negedge clk);
      d = '{1, 1, 1, 1}; send_frame(NODE, 0, d); check_reply("post_rst_w");
      d = '{2, 2, 2, 2}; send_frame(NODE, 1, d); check_reply("post_rst_x");

      // reset while the reply is on the wire
      d = '{3, 3, 3, 3}; send_frame(NODE, 0, d); check_reply("pre_abort_w");
      d = '{1, 1, 1, 1}; send_frame(NODE, 1, d);
      found = 1'b0;
      for (int i = 0; i < 60 * BAUD && !found; i++) begin
         @(negedge clk);
         if (uart_tx === 1'b0) found = 1'b1;
      end
      chk("abort_tx_seen_low", found, 1);
      nRst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_tx_high", uart_tx, 1);
      @(negedge clk);
      nRst = 1'b0;
      w_m = '{default: 0};
      x_m = '{default: 0};
      exp_q.delete();
      repeat (20 * BAUD) @(negedge clk);
      got_q.delete();
      st_q.delete();
      d = '{5, 6, 7, 8}; send_frame(NODE, 1, d); check_reply("zero_weights");

      // randomized frames
      for (int t = 0; t < 10; t++) begin
         a = NODE;
         if ($urandom_range(0, 3) == 0) begin
            a = $urandom_range(0, 255);
            if (a == NODE) a = NODE + 1;
         end
         o = $urandom_range(0, 2);
         if (o == 2) o = $urandom_range(2, 255);
         for (int i = 0; i < 4; i++) d[i] = $urandom_range(0, 255);
         send_frame(a, o, d);
         check_reply($sformatf("rand%0d", t));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/perceptron_core.md
# perceptron_core

Single-neuron perceptron reached over a UART link. A host addresses it with byte frames that load four 8-bit weights or four 8-bit inputs. Loading inputs triggers a multiply-accumulate, and the weighted sum plus a threshold decision go back to the host on the transmit line. It sits as a leaf node on the shared host serial bus.

## Interface
- `BAUD_DIV`, default 430: clock cycles per UART bit (50 MHz / 430 ≈ 116.3 kbaud, 8.6 µs bit).
- `NODE_ADDR`, default 100: address byte this node answers to.
- `N_IN`, default 4: number of inputs and weights.
- `THRESHOLD`, default 255: activation is 1 when the sum is strictly greater than this value.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `nRst`  in  1: reset, synchronous and active-high (codebase name kept).
- `host_tx`  in  1: serial data from the host; idle high, asynchronous to `clk`.
- `uart_tx`  out  1: serial data to the host; idle high.

## Operation
- UART format is 8N1, LSB first.
- Rx path:
  - `host_tx` passes through a 2-FF synchroniser.
  - A falling edge in idle starts a byte.
  - The start bit is re-checked low at half a bit, else the receiver returns to idle.
  - Data bits are sampled at bit centres, every `BAUD_DIV` cycles.
  - The stop bit is sampled and must be high; otherwise the byte is dropped (framing error).
- Frame: ADDR, OPCODE, then `N_IN` data bytes D0..D3.
- Parser FSM states: `IDLE`, `OPC`, `DATA`, `SKIP`, `CALC`, `SEND`.
  - `IDLE`: byte == `NODE_ADDR` → `OPC`; any other byte → `SKIP` for 5 bytes.
  - `OPC`: latch the opcode, clear the data index, go to `DATA`.
  - `DATA`, opcode 0: store each byte in `w[idx]`.
  - `DATA`, opcode 1: store each byte in `x[idx]`.
  - `DATA`, any other opcode: discard the bytes.
  - `DATA` exit, after the 4th byte: opcode 1 → `CALC`; otherwise → `IDLE`.
  - `CALC`: sum = Σ w[i]·x[i], unsigned, 8×8 → 16-bit products, 18-bit accumulator with no overflow possible. One MAC per cycle, 4 cycles.
  - `SEND`: transmit 4 bytes: sum[7:0], sum[15:8], {6'b0,sum[17:16]}, then act, where act = 8'h01 if sum > `THRESHOLD` else 8'h00. Return to `IDLE`.
- Bytes arriving during `CALC`/`SEND` are still parsed normally.
  - A new opcode-1 frame that completes while `SEND` is busy is queued once: it computes after the current reply finishes. Further completions overwrite that pending request.
- Weights persist across frames until reloaded or reset.

## Timing
- Reset values:
  - `uart_tx` = 1; all weights, inputs and accumulator = 0.
  - FSM in `IDLE`; Rx and Tx idle.
- Reset takes effect on the next edge mid-byte: a partial frame is discarded and the Tx line returns high immediately.
- The Rx byte strobe is 1 cycle wide, asserted at the stop-bit sample.
- Reply latency: the start bit of the first reply byte begins ≤ 8 cycles after the strobe of the 4th data byte.
- Reply bytes are sent back-to-back: one stop bit, then the next start bit.
- Each reply byte lasts 10·`BAUD_DIV` cycles.
- The bit counter wraps exactly at `BAUD_DIV`-1 with no cumulative drift; a one-cycle late start-edge detect is acceptable.

## Structure
- Package `perceptron_pkg`:
  - `OPC_LOAD_W` = 8'h00, `OPC_LOAD_X` = 8'h01.
  - FSM state enum.
  - `SUM_W` = 18, `DATA_W` = 8.
- One sub-module, `perceptron_uart`, holds the Rx (sync, sampler, strobe) and Tx (shift register, busy) paths.
- Parser, register file, MAC and reply sequencer live in the top module.

## Test plan
- Reset, then idle 1 ms → `uart_tx` stays high throughout; no byte emitted.
- Send 100,0,1,2,3,4 (weights), then 100,1,10,20,30,40:
  - After the first frame: no reply.
  - After the second frame: reply 0x2C,0x01,0x00,0x01 (sum 300 > 255).
- Weights 1,2,3,4 loaded; send inputs 100,1,1,1,1,1 → reply 0x0A,0x00,0x00,0x00 (sum 10).
- Send 99,1,10,20,30,40 (wrong address), then a valid input frame → exactly one reply, for the valid frame only.
- Weights and inputs all 255 → reply 0x04,0xF8,0x03,0x01 (sum 260100).
- Send a byte with the stop bit forced low inside a frame → that byte is ignored; after reset the frame parses from ADDR again. Also assert `nRst` mid-reply → `uart_tx` is high on the next cycle and weights read back as zero (next compute replies 0x00,0x00,0x00,0x00).
